// File: rtl/logic_sel_pkg.sv
// Shared definitions for the OR/AND logic selector and its BIST initiator.
// Pure package: no latency, no flow control.
package logic_sel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [7:0] LFSR_TAPS    = 8'hB8;
   localparam logic [7:0] DEFAULT_SEED = 8'hA5;

   // One in-flight expectation travelling alongside the selector latency.
   typedef struct packed {
      logic       vld;
      logic [7:0] idx;
      logic [7:0] expd;
   } chk_t;

   function automatic logic [7:0] sel_op(input logic [7:0] a, input logic [7:0] b);
      return a[7] ? (a | b) : (a & b);
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit right-shifting Galois LFSR with synchronous load and step enable.
// One cycle from load/step to new value; no backpressure.
module lfsr8
   import logic_sel_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       step,
   input  logic [7:0] seed,
   output logic [7:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= 8'h01;
      end else if (load) begin
         value <= seed;
      end else if (step) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/logic_sel_stim_checker.sv
// BIST initiator: drives pseudo-random operand pairs into the logic selector and scores its results.
// Results checked LATENCY+1 edges after each vector; start is ignored while busy.
module logic_sel_stim_checker
   import logic_sel_pkg::*;
#(
   parameter int         N_VECTORS = 64,
   parameter logic [7:0] SEED      = DEFAULT_SEED,
   parameter int         LATENCY   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] a_out,
   output logic [7:0] b_out,
   output logic       en_out,
   input  logic [7:0] c_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] first_fail_idx
);

   // An all-zero Galois LFSR never leaves zero, so substitute 1.
   localparam logic [7:0] SEED_A     = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] SEED_B     = {SEED_A[3:0], SEED_A[7:4]};
   localparam logic [7:0] LAST_IDX   = 8'(N_VECTORS - 1);
   localparam logic [1:0] DRAIN_LAST = 2'(LATENCY - 1);
   localparam logic [7:0] NO_FAIL    = 8'hFF;

   state_t     state;
   state_t     state_nxt;
   logic       launch;
   logic       driving;
   logic [7:0] lfsr_a;
   logic [7:0] lfsr_b;
   logic [7:0] idx;
   logic [1:0] drain_cnt;
   chk_t       pipe [LATENCY];
   chk_t       head;
   logic       mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               launch    = 1'b1;
               state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (idx == LAST_IDX) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign driving = (state == ST_DRIVE);

   lfsr8 u_lfsr_a (
      .clk   (clk),
      .rst   (rst),
      .load  (launch),
      .step  (driving),
      .seed  (SEED_A),
      .value (lfsr_a)
   );

   lfsr8 u_lfsr_b (
      .clk   (clk),
      .rst   (rst),
      .load  (launch),
      .step  (driving),
      .seed  (SEED_B),
      .value (lfsr_b)
   );

   assign a_out  = driving ? lfsr_a : 8'h00;
   assign b_out  = driving ? lfsr_b : 8'h00;
   assign en_out = driving;
   assign busy   = (state == ST_DRIVE) || (state == ST_DRAIN);
   assign done   = (state == ST_DONE);
   assign pass   = done && (err_count == 8'h00);

   // Expectation rides a shift register so it meets the selector's result at c_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pipe[0] <= '{vld: driving, idx: idx, expd: sel_op(a_out, b_out)};
         for (int k = 1; k < LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
         end
      end
   end

   assign head     = pipe[LATENCY-1];
   assign mismatch = head.vld && (c_in != head.expd);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= 8'h00;
         drain_cnt      <= 2'd0;
         err_count      <= 8'h00;
         first_fail_idx <= NO_FAIL;
      end else begin
         if (launch) begin
            idx <= 8'h00;
         end else if (driving) begin
            idx <= idx + 8'd1;
         end

         if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 2'd1;
         end else begin
            drain_cnt <= 2'd0;
         end

         if (launch) begin
            err_count      <= 8'h00;
            first_fail_idx <= NO_FAIL;
         end else if (mismatch) begin
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
            if (first_fail_idx == NO_FAIL) begin
               first_fail_idx <= head.idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_sel_stim_checker.sv
// Scoreboarded bench: a behavioural selector (with injectable faults) answers the DUT,
// a reference model predicts every vector and each run's verdict, and a monitor compares.
module tb_logic_sel_stim_checker;

   localparam int         N    = 64;
   localparam int         LAT  = 1;
   localparam logic [7:0] SEED = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_out, b_out, c_in, err_count, first_fail_idx;
   logic       en_out, busy, done, pass;

   logic_sel_stim_checker #(
      .N_VECTORS (N),
      .SEED      (SEED),
      .LATENCY   (LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .a_out          (a_out),
      .b_out          (b_out),
      .en_out         (en_out),
      .c_in           (c_in),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_fail_idx (first_fail_idx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // Fault injection: 0 none, 1 stuck-at-0 on bit fault_arg, 2 XOR fault_mask into vector fault_arg.
   int         fault_kind = 0;
   int         fault_arg  = 0;
   logic [7:0] fault_mask = 8'h00;

   function automatic logic [7:0] ref_sel(input logic [7:0] a, input logic [7:0] b);
      if (a >= 8'd128) return a | b;
      return a & b;
   endfunction

   function automatic logic [7:0] ref_step(input logic [7:0] s);
      logic [7:0] half;
      half = s / 8'd2;
      return (s % 8'd2 == 8'd1) ? (half ^ 8'd184) : half;
   endfunction

   function automatic logic [7:0] apply_fault(input logic [7:0] c, input int vi);
      logic [7:0] m;
      m = 8'(1 << fault_arg);
      case (fault_kind)
         1:       return c & ~m;
         2:       return (vi == fault_arg) ? (c ^ fault_mask) : c;
         default: return c;
      endcase
   endfunction

   // Behavioural selector with one registered cycle of latency.
   int         sel_vi = 0;
   logic [7:0] sel_q = 8'h00;
   assign c_in = sel_q;
   always @(posedge clk) begin
      if (en_out) begin
         sel_q  <= apply_fault(ref_sel(a_out, b_out), sel_vi);
         sel_vi <= sel_vi + 1;
      end else begin
         sel_vi <= 0;
      end
   end

   typedef struct {
      int cyc;
      int err;
      int ffi;
      int pass;
   } sum_t;

   logic [15:0] vecq[$];
   sum_t        sumq[$];

   // Predict one run: queue every operand pair, return the verdict.
   task automatic expect_run(output int err, output int ffi);
      logic [7:0] a, b, ideal;
      a   = (SEED == 8'h00) ? 8'h01 : SEED;
      b   = 8'((a % 8'd16) * 8'd16 + (a / 8'd16));
      err = 0;
      ffi = 255;
      for (int i = 0; i < N; i++) begin
         vecq.push_back({a, b});
         ideal = ref_sel(a, b);
         if (apply_fault(ideal, i) != ideal) begin
            if (err < 255) err++;
            if (ffi == 255) ffi = i;
         end
         a = ref_step(a);
         b = ref_step(b);
      end
   endtask

   task automatic push_sum(input int dcyc, input int err, input int ffi);
      sum_t s;
      s.cyc  = dcyc;
      s.err  = err;
      s.ffi  = ffi;
      s.pass = (err == 0) ? 1 : 0;
      sumq.push_back(s);
   endtask

   task automatic wait_drained(input int budget);
      for (int t = 0; t < budget && sumq.size() != 0; t++) @(negedge clk);
      @(posedge clk);
      #1;
      check("run_completed", sumq.size(), 0);
      check("vectors_consumed", vecq.size(), 0);
      sumq.delete();
      vecq.delete();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_en"}, en_out, 0);
      check({tag, "_err"}, err_count, 0);
      check({tag, "_ffi"}, first_fail_idx, 8'hFF);
      check({tag, "_a"}, a_out, 0);
      check({tag, "_b"}, b_out, 0);
   endtask

   // opt: 1 = pulse start mid-run, 2 = pin the first vector to its literal values
   task automatic do_run(input int kind, input int arg, input logic [7:0] mask, input int opt);
      int err, ffi, sc;
      fault_kind = kind;
      fault_arg  = arg;
      fault_mask = mask;
      expect_run(err, ffi);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1;
      sc    = cyc;
      start = 1'b0;
      push_sum(sc + N + LAT, err, ffi);
      if (opt == 2) begin
         check("first_a", a_out, 8'hA5);
         check("first_b", b_out, 8'h5A);
         check("first_en", en_out, 1);
      end
      if (opt == 1) begin
         repeat (5) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      wait_drained(N + LAT + 20);
   endtask

   task automatic do_held_restart();
      int err1, ffi1, err2, ffi2, sc;
      fault_kind = 2;
      fault_arg  = 3;
      fault_mask = 8'h80;
      expect_run(err1, ffi1);
      expect_run(err2, ffi2);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 sc = cyc;
      push_sum(sc + N + LAT, err1, ffi1);
      push_sum(sc + 2 * (N + LAT) + 1, err2, ffi2);
      for (int t = 0; t < N + LAT + 20 && sumq.size() > 1; t++) @(negedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      wait_drained(N + LAT + 20);
   endtask

   // Monitor: operand stream and end-of-run verdicts against the scoreboard.
   logic        done_prev = 1'b0;
   logic [15:0] mon_v;
   sum_t        mon_s;
   always @(negedge clk) begin
      if (!rst) begin
         if (en_out) begin
            check("vector_expected", int'(vecq.size() != 0), 1);
            if (vecq.size() != 0) begin
               mon_v = vecq.pop_front();
               check("a_out", a_out, mon_v[15:8]);
               check("b_out", b_out, mon_v[7:0]);
               check("busy_drive", busy, 1);
            end
         end else begin
            check("a_quiet", a_out, 0);
            check("b_quiet", b_out, 0);
         end
         if (done && !done_prev) begin
            check("verdict_expected", int'(sumq.size() != 0), 1);
            if (sumq.size() != 0) begin
               mon_s = sumq.pop_front();
               check("done_cycle", cyc, mon_s.cyc);
               check("err_count", err_count, mon_s.err);
               check("first_fail_idx", first_fail_idx, mon_s.ffi);
               check("pass", pass, mon_s.pass);
               check("busy_at_done", busy, 0);
            end
         end
      end
      done_prev = done;
   end

   initial begin
      int err_unused, ffi_unused, kind, arg;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_idle("reset");
      rst = 1'b0;

      do_run(0, 0, 8'h00, 2);   // clean run with literal first vector
      do_run(1, 0, 8'h00, 0);   // c_in[0] stuck at 0
      do_run(2, 5, 8'h10, 0);   // only vector 5 corrupted
      do_run(0, 0, 8'h00, 1);   // start pulsed while driving

      // Reset while vector 10 is on the bus.
      fault_kind = 0;
      expect_run(err_unused, ffi_unused);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 check_idle("midrun_reset");
      vecq.delete();
      rst = 1'b0;
      do_run(0, 0, 8'h00, 2);

      do_held_restart();

      repeat (4) begin
         kind = int'($urandom_range(0, 2));
         arg  = (kind == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, N - 1));
         do_run(kind, arg, 8'($urandom_range(1, 255)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
